// File: rtl/ttt_move_arbiter.sv
// ttt_move_arbiter: tic-tac-toe turn controller.
// Validates X/O moves, owns the board, detects win, cats and timeout.
module ttt_move_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqX,
  input  logic [3:0] posX,
  input  logic       reqO,
  input  logic [3:0] posO,
  output logic       ackX,
  output logic       nakX,
  output logic       ackO,
  output logic       nakO,
  output logic       turnX,
  output logic       turnO,
  output logic [8:0] occ_square,
  output logic [8:0] occ_player,
  output logic [3:0] move_cnt,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       timeout_forfeit
);

  typedef enum logic [2:0] {
    IDLE, WAIT_X, CHK_X, WAIT_O, CHK_O, DONE
  } state_t;

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, nxt;
  logic             reqX_q, reqO_q;
  logic             edgeX, edgeO;
  logic [3:0]       pos_q;
  logic [CNT_W-1:0] timer;
  logic             expired, legal, accept;
  logic             win_now, full_now;
  logic [15:0]      occ_ext;
  logic [8:0]       sq_bit, mine_nxt;
  logic [3:0]       cnt_nxt;

  function automatic logic has_trey(input logic [8:0] b);
    has_trey = ((b & 9'b100100100) == 9'b100100100) ||
               ((b & 9'b010010010) == 9'b010010010) ||
               ((b & 9'b001001001) == 9'b001001001) ||
               ((b & 9'b111000000) == 9'b111000000) ||
               ((b & 9'b000111000) == 9'b000111000) ||
               ((b & 9'b000000111) == 9'b000000111) ||
               ((b & 9'b100010001) == 9'b100010001) ||
               ((b & 9'b001010100) == 9'b001010100);
  endfunction

  // Win test looks at the board as it will be after this move.
  always_comb begin
    edgeX    = reqX & ~reqX_q;
    edgeO    = reqO & ~reqO_q;
    expired  = (timer == T_LAST);
    occ_ext  = {7'd0, occ_square};
    legal    = (pos_q <= 4'd8) && !occ_ext[pos_q];
    sq_bit   = 9'd1 << pos_q;
    mine_nxt = sq_bit | ((state == CHK_X) ?
               (occ_square & occ_player) :
               (occ_square & ~occ_player));
    win_now  = has_trey(mine_nxt);
    cnt_nxt  = (move_cnt == 4'd9) ? 4'd9 : move_cnt + 4'd1;
    full_now = (cnt_nxt == 4'd9);
    accept   = ((state == CHK_X) || (state == CHK_O)) && legal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = WAIT_X;
      WAIT_X: begin
        if (edgeX)        nxt = CHK_X;
        else if (expired) nxt = DONE;
      end
      CHK_X: begin
        if (!legal)                nxt = WAIT_X;
        else if (win_now || full_now) nxt = DONE;
        else                       nxt = WAIT_O;
      end
      WAIT_O: begin
        if (edgeO)        nxt = CHK_O;
        else if (expired) nxt = DONE;
      end
      CHK_O: begin
        if (!legal)                nxt = WAIT_O;
        else if (win_now || full_now) nxt = DONE;
        else                       nxt = WAIT_X;
      end
      DONE:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    turnX     = (state == WAIT_X) || (state == CHK_X);
    turnO     = (state == WAIT_O) || (state == CHK_O);
    game_over = (state == DONE);
  end

  // Timer saturates so an expiry reached during CHK fires in the next WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqX_q          <= 1'b0;
      reqO_q          <= 1'b0;
      pos_q           <= '0;
      timer           <= '0;
      ackX            <= 1'b0;
      nakX            <= 1'b0;
      ackO            <= 1'b0;
      nakO            <= 1'b0;
      occ_square      <= '0;
      occ_player      <= '0;
      move_cnt        <= '0;
      winner          <= 2'b00;
      timeout_forfeit <= 1'b0;
    end else begin
      reqX_q <= reqX;
      reqO_q <= reqO;
      ackX   <= 1'b0;
      nakX   <= 1'b0;
      ackO   <= 1'b0;
      nakO   <= 1'b0;
      if ((state == IDLE) || accept)
        timer <= '0;
      else if ((state != DONE) && (timer != T_LAST))
        timer <= timer + 1'b1;
      unique case (state)
        WAIT_X: begin
          nakO <= edgeO;
          if (edgeX) pos_q <= posX;
          else if (expired) begin
            winner          <= 2'b10;
            timeout_forfeit <= 1'b1;
          end
        end
        WAIT_O: begin
          nakX <= edgeX;
          if (edgeO) pos_q <= posO;
          else if (expired) begin
            winner          <= 2'b01;
            timeout_forfeit <= 1'b1;
          end
        end
        CHK_X: begin
          nakO <= edgeO;
          if (!legal) nakX <= 1'b1;
          else begin
            occ_square <= occ_square | sq_bit;
            occ_player <= occ_player | sq_bit;
            move_cnt   <= cnt_nxt;
            ackX       <= 1'b1;
            if (win_now)       winner <= 2'b01;
            else if (full_now) winner <= 2'b11;
          end
        end
        CHK_O: begin
          nakX <= edgeX;
          if (!legal) nakO <= 1'b1;
          else begin
            occ_square <= occ_square | sq_bit;
            occ_player <= occ_player & ~sq_bit;
            move_cnt   <= cnt_nxt;
            ackO       <= 1'b1;
            if (win_now)       winner <= 2'b10;
            else if (full_now) winner <= 2'b11;
          end
        end
        DONE: begin
          nakX <= edgeX;
          nakO <= edgeO;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_move_arbiter.sv
// tb_ttt_move_arbiter: scoreboard bench for the tic-tac-toe arbiter.
// A move-level game model predicts each ack/nak/game-over event and its cycle.
module tb_ttt_move_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reqX = 1'b0, reqO = 1'b0;
  logic [3:0] posX = '0, posO = '0;
  logic       ackX, nakX, ackO, nakO, turnX, turnO;
  logic [8:0] occ_square, occ_player;
  logic [3:0] move_cnt;
  logic       game_over, timeout_forfeit;
  logic [1:0] winner;

  always #5 clk = ~clk;

  ttt_move_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .reqX(reqX), .posX(posX), .reqO(reqO), .posO(posO),
    .ackX(ackX), .nakX(nakX), .ackO(ackO), .nakO(nakO),
    .turnX(turnX), .turnO(turnO),
    .occ_square(occ_square), .occ_player(occ_player),
    .move_cnt(move_cnt), .game_over(game_over),
    .winner(winner), .timeout_forfeit(timeout_forfeit)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        ax, nx, ao, no;
    logic [8:0]  sq, pl;
    logic [3:0]  mc;
    logic [1:0]  w;
    logic        go, tf, tx, to;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // game model
  int       turn;
  bit       done;
  int       deadline;
  bit [8:0] m_occ, m_x;
  int       m_cnt;
  bit [1:0] m_win;
  bit       m_tf;
  int       treys[8] = '{852, 741, 630, 876, 543, 210, 840, 642};
  int       g_xwin[5] = '{0, 4, 1, 8, 2};
  int       g_cats[9] = '{4, 0, 2, 6, 3, 5, 1, 7, 8};

  function automatic bit owns_trey(bit xs);
    for (int i = 0; i < 8; i++) begin
      int a = treys[i] / 100;
      int b = (treys[i] / 10) % 10;
      int d = treys[i] % 10;
      if (m_occ[a] && m_occ[b] && m_occ[d] &&
          m_x[a] == xs && m_x[b] == xs && m_x[d] == xs)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int pick_empty();
    int q[$];
    for (int i = 0; i < 9; i++)
      if (!m_occ[i]) q.push_back(i);
    if (q.size() == 0) return 0;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic push_ev(int at, bit ax, bit nx, bit ao, bit no);
    ev_t e;
    e.cyc = 32'(at);
    e.ax = ax; e.nx = nx; e.ao = ao; e.no = no;
    e.sq = m_occ; e.pl = m_x;
    e.mc = 4'(m_cnt); e.w = m_win;
    e.go = done; e.tf = m_tf;
    e.tx = !done && turn == 0;
    e.to = !done && turn == 1;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expire(bit nx, bit no);
    done  = 1'b1;
    m_win = (turn == 0) ? 2'b10 : 2'b01;
    m_tf  = 1'b1;
    push_ev(cyc + 1, 1'b0, nx, 1'b0, no);
  endtask

  task automatic idle_cycle();
    if (!done && cyc >= deadline) expire(1'b0, 1'b0);
    tick();
  endtask

  task automatic resolve(int p);
    bit ok, ax;
    ok = (p > 8) ? 1'b0 : !m_occ[p];
    ax = (turn == 0);
    if (!ok) push_ev(cyc, 1'b0, ax, 1'b0, !ax);
    else begin
      m_occ[p] = 1'b1;
      m_x[p]   = ax;
      m_cnt++;
      if (owns_trey(ax)) begin
        done  = 1'b1;
        m_win = ax ? 2'b01 : 2'b10;
      end else if (m_cnt == 9) begin
        done  = 1'b1;
        m_win = 2'b11;
      end
      if (!done) begin
        turn     = 1 - turn;
        deadline = cyc + T - 1;
      end
      push_ev(cyc, ax, 1'b0, !ax, 1'b0);
    end
  endtask

  task automatic act(bit dx, bit dO, int px, int po);
    bit own = (turn == 0) ? dx : dO;
    bit oth = (turn == 0) ? dO : dx;
    int p   = (turn == 0) ? px : po;
    int c   = cyc;
    reqX = dx; reqO = dO;
    posX = 4'(px); posO = 4'(po);
    if (done) begin
      push_ev(c + 1, 1'b0, dx, 1'b0, dO);
      tick(); reqX = 0; reqO = 0; tick();
    end else if (!own) begin
      if (c >= deadline) expire(turn == 1, turn == 0);
      else push_ev(c + 1, 1'b0, turn == 1, 1'b0, turn == 0);
      tick(); reqX = 0; reqO = 0; idle_cycle();
    end else begin
      if (oth) push_ev(c + 1, 1'b0, turn == 1, 1'b0, turn == 0);
      tick(); reqX = 0; reqO = 0; tick();
      resolve(p);
    end
  endtask

  task automatic mv(int p);
    if (turn == 0) act(1'b1, 1'b0, p, 0);
    else           act(1'b0, 1'b1, 0, p);
  endtask

  task automatic chk_zero(string nm);
    logic [31:0] v;
    v = {ackX, nakX, ackO, nakO, turnX, turnO, occ_square,
         occ_player, move_cnt, game_over, winner, timeout_forfeit};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs %h, want 0", nm, v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1; reqX = 0; reqO = 0;
    #1 chk_zero("async_reset");
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d events unseen, want 0", sbq.size());
    end
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    turn = 0; done = 0; deadline = T;
    m_occ = '0; m_x = '0; m_cnt = 0; m_win = '0; m_tf = 0;
    tick();
  endtask

  // monitor: every ack/nak pulse or game_over rise is one event
  logic go_q = 1'b0;
  ev_t  act_ev, exp_ev;
  always @(negedge clk) begin
    if (!reset && (ackX | nakX | ackO | nakO | (game_over & !go_q))) begin
      act_ev = {32'(cyc), ackX, nakX, ackO, nakO, occ_square, occ_player,
                move_cnt, winner, game_over, timeout_forfeit, turnX, turnO};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h, want none", act_ev);
      end else begin
        exp_ev = sbq.pop_front();
        if (act_ev !== exp_ev) begin
          errors++;
          $display("FAIL event: got %h, want %h", act_ev, exp_ev);
        end
      end
    end
    go_q <= reset ? 1'b0 : game_over;
  end

  initial begin
    // first X move, then mid-game reset
    do_reset();
    mv(4);
    mv(3);
    // wrong-player edge, then simultaneous edges
    do_reset();
    act(1'b0, 1'b1, 0, 5);
    act(1'b1, 1'b1, 4, 5);
    // occupied / out-of-range, turn timer keeps running
    do_reset();
    mv(4);
    mv(4);
    mv(12);
    repeat (8) idle_cycle();
    // X wins on 210, then nak in DONE
    do_reset();
    foreach (g_xwin[i]) mv(g_xwin[i]);
    act(1'b0, 1'b1, 0, 3);
    // cats
    do_reset();
    foreach (g_cats[i]) mv(g_cats[i]);
    act(1'b1, 1'b1, 5, 6);
    // X timeout with no requests
    do_reset();
    repeat (12) idle_cycle();
    act(1'b1, 1'b0, 0, 0);
    // random games
    for (int g = 0; g < 30; g++) begin
      do_reset();
      for (int s = 0; s < 40 && !done; s++) begin
        int r = $urandom_range(0, 9);
        if (r < 2)
          repeat ($urandom_range(1, (r == 0) ? 9 : 2)) idle_cycle();
        else if (r == 2) begin
          if (turn == 0) act(1'b0, 1'b1, 0, $urandom_range(0, 15));
          else           act(1'b1, 1'b0, $urandom_range(0, 15), 0);
        end else if (r == 3)
          act(1'b1, 1'b1, pick_empty(), pick_empty());
        else if (r == 4)
          mv($urandom_range(0, 15));
        else
          mv(pick_empty());
      end
      act(1'b1, 1'b0, pick_empty(), 0);
    end
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
